// File: rtl/pc_pkg.sv
// Shared definitions for the program counter: operation encoding, request priority
// order and a constant-evaluable clog2 for sizing the return-stack pointer.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_BRANCH,
    OP_INCR
  } op_e;

  localparam int unsigned NUM_PRIO = 5;

  // Index 0 is the highest priority.
  localparam op_e OP_PRIO [NUM_PRIO] = '{OP_LOAD, OP_CALL, OP_RET, OP_BRANCH, OP_INCR};

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

  // req[i] corresponds to OP_PRIO[i]; the highest-priority asserted request wins.
  function automatic op_e pick_op(input logic [NUM_PRIO-1:0] req);
    op_e op;
    op = OP_NONE;
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      if (req[i]) op = OP_PRIO[i];
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_call_stack_if.sv
// Request/response bundle between the fetch controller and the program counter.
interface pc_call_stack_if #(
  parameter int unsigned SIZE = 8
);
  logic            incr;
  logic            load;
  logic            branch;
  logic            call;
  logic            ret;
  logic [SIZE-1:0] addr;
  logic [SIZE-1:0] offset;
  logic [SIZE-1:0] out;
  logic            stack_full;
  logic            stack_empty;
  logic            stack_err;

  modport master (
    output incr, load, branch, call, ret, addr, offset,
    input  out, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  incr, load, branch, call, ret, addr, offset,
    output out, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses. Push-when-full and pop-when-empty are silently ignored;
// full/empty are registered so they carry no input-to-output path.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned SIZE        = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int unsigned PTR_W = clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? clog2(STACK_DEPTH) : 1;

  logic [SIZE-1:0]  mem_q [2**IDX_W];
  logic [PTR_W-1:0] depth_q, depth_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q & ~do_push;
  assign wr_idx  = IDX_W'(depth_q);
  assign rd_idx  = IDX_W'(depth_q - PTR_W'(1));

  always_comb begin
    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + PTR_W'(1);
    else if (do_pop) depth_d = depth_q - PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      depth_q <= depth_d;
      full_q  <= (depth_d == PTR_W'(STACK_DEPTH));
      empty_q <= (depth_d == '0);
    end
  end

  // Storage is not reset; entries above depth are don't-care.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_idx] <= din;
  end

  assign dout  = mem_q[rd_idx];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/pc_call_stack.sv
// Program counter with jump, relative branch, and call/return through a return stack.
// One operation per cycle chosen by fixed priority; all outputs are registered.
module pc_call_stack
  import pc_pkg::*;
#(
  parameter int unsigned   SIZE        = 8,
  parameter int unsigned   STACK_DEPTH = 4,
  parameter bit            EDGE_INCR   = 1'b1,
  parameter logic [SIZE-1:0] RESET_ADDR  = '0
) (
  input logic           clk,
  input logic           reset,
  pc_call_stack_if.slave bus
);

  logic [SIZE-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic            incr_prev_q;
  logic            incr_go;
  logic            push, pop;
  logic [SIZE-1:0] stack_top;
  logic            stack_full, stack_empty;
  op_e             op;

  assign incr_go = EDGE_INCR ? (bus.incr & ~incr_prev_q) : bus.incr;
  assign op      = pick_op({incr_go, bus.branch, bus.ret, bus.call, bus.load});

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    unique case (op)
      OP_LOAD: pc_d = bus.addr;
      OP_CALL: begin
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          push = 1'b1;
          pc_d = bus.addr;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          err_d = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = stack_top;
        end
      end
      OP_BRANCH: pc_d = pc_q + bus.offset;
      OP_INCR:   pc_d = pc_q + SIZE'(1);
      default:   ;
    endcase
  end

  // incr history tracks the raw input every cycle, so an edge lost to a
  // higher-priority op is not replayed later.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_ADDR;
      err_q       <= 1'b0;
      incr_prev_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      err_q       <= err_d;
      incr_prev_q <= bus.incr;
    end
  end

  pc_ret_stack #(
    .SIZE        (SIZE),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_q + SIZE'(1)),
    .dout  (stack_top),
    .full  (stack_full),
    .empty (stack_empty)
  );

  assign bus.out         = pc_q;
  assign bus.stack_full  = stack_full;
  assign bus.stack_empty = stack_empty;
  assign bus.stack_err   = err_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_pc_call_stack;

  logic clk;
  logic reset;

  pc_call_stack_if #(.SIZE(8)) bus_if ();

  pc_call_stack #(
    .SIZE        (8),
    .STACK_DEPTH (4),
    .EDGE_INCR   (1'b1),
    .RESET_ADDR  (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    string      name;
    logic [7:0] out;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec;
  int   n_miss;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
    $fatal(1);
  end

  // Monitor: outputs settle after posedge, sampled at the following negedge.
  initial begin
    exp_t e;
    logic [10:0] got, want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        got  = {bus_if.out, bus_if.stack_full, bus_if.stack_empty, bus_if.stack_err};
        want = {e.out, e.full, e.empty, e.err};
        n_vec++;
        if (got !== want) begin
          n_miss++;
          $display("FAIL %s: got out=%h full=%b empty=%b err=%b, required out=%h full=%b empty=%b err=%b",
                   e.name, bus_if.out, bus_if.stack_full, bus_if.stack_empty, bus_if.stack_err,
                   e.out, e.full, e.empty, e.err);
        end
      end
    end
  end

  task automatic apply(input string name, input logic rst, input logic inc, input logic ld,
                       input logic br, input logic cl, input logic rt, input logic [7:0] a,
                       input logic [7:0] off, input logic [7:0] e_out, input logic e_full,
                       input logic e_empty, input logic e_err);
    exp_t e;
    reset         = rst;
    bus_if.incr   = inc;
    bus_if.load   = ld;
    bus_if.branch = br;
    bus_if.call   = cl;
    bus_if.ret    = rt;
    bus_if.addr   = a;
    bus_if.offset = off;
    @(posedge clk);
    e.name  = name;
    e.out   = e_out;
    e.full  = e_full;
    e.empty = e_empty;
    e.err   = e_err;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    bus_if.incr = 1'b0; bus_if.load = 1'b0; bus_if.branch = 1'b0;
    bus_if.call = 1'b0; bus_if.ret  = 1'b0; bus_if.addr = '0; bus_if.offset = '0;

    //    name           rst inc ld br cl rt addr   off    out   full empty err
    apply("reset0",       1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    apply("reset1",       1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    apply("incr_edge",    0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      apply("incr_held",  0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0);
    apply("incr_low",     0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 0, 1, 0);

    apply("load_ff",      0, 0, 1, 0, 0, 0, 8'hFF, 8'h00, 8'hFF, 0, 1, 0);
    apply("incr_wrap",    0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    apply("idle",         0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    apply("load_10",      0, 0, 1, 0, 0, 0, 8'h10, 8'h00, 8'h10, 0, 1, 0);
    apply("branch_neg",   0, 0, 0, 1, 0, 0, 8'h00, 8'hFE, 8'h0E, 0, 1, 0);
    apply("branch_pos",   0, 0, 0, 1, 0, 0, 8'h00, 8'h05, 8'h13, 0, 1, 0);

    apply("load_05",      0, 0, 1, 0, 0, 0, 8'h05, 8'h00, 8'h05, 0, 1, 0);
    apply("call_40",      0, 0, 0, 0, 1, 0, 8'h40, 8'h00, 8'h40, 0, 0, 0);
    apply("ret_06",       0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h06, 0, 1, 0);

    apply("call_a",       0, 0, 0, 0, 1, 0, 8'h10, 8'h00, 8'h10, 0, 0, 0);
    apply("call_b",       0, 0, 0, 0, 1, 0, 8'h20, 8'h00, 8'h20, 0, 0, 0);
    apply("call_c",       0, 0, 0, 0, 1, 0, 8'h30, 8'h00, 8'h30, 0, 0, 0);
    apply("call_full",    0, 0, 0, 0, 1, 0, 8'h50, 8'h00, 8'h50, 1, 0, 0);
    apply("call_ovf",     0, 0, 0, 0, 1, 0, 8'h99, 8'h00, 8'h50, 1, 0, 1);
    apply("ret_31",       0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h31, 0, 0, 1);
    apply("ret_21",       0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h21, 0, 0, 1);
    apply("ret_11",       0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 0, 0, 1);
    apply("ret_07",       0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h07, 0, 1, 1);
    apply("ret_udf",      0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h07, 0, 1, 1);

    apply("reset_clr",    1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
    apply("prio_load",    0, 1, 1, 0, 1, 0, 8'h20, 8'h00, 8'h20, 0, 1, 0);
    apply("edge_lost",    0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h20, 0, 1, 0);
    apply("incr_rel",     0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h20, 0, 1, 0);
    apply("incr_again",   0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h21, 0, 1, 0);
    apply("prio_call",    0, 0, 0, 1, 1, 1, 8'h60, 8'h10, 8'h60, 0, 0, 0);
    apply("call_70",      0, 0, 0, 0, 1, 0, 8'h70, 8'h00, 8'h70, 0, 0, 0);
    apply("reset_call",   1, 0, 0, 0, 1, 0, 8'h80, 8'h00, 8'h00, 0, 1, 0);
    apply("ret_after_rst",0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 1, 1);

    bus_if.ret = 1'b0;
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked vectors, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
